// File: rtl/mem_access.sv
// mem_access: ME-stage load/store unit with a registered memory handshake and a BUSY timeout.
// Define MEM_ALIGN_CHK_EN to reject misaligned half/word accesses instead of force-aligning them.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ME_MemRd,
    input  logic        ME_MemWr,
    input  logic [2:0]  ME_MemOp,
    input  logic [31:0] ME_ALURes,
    input  logic [31:0] ME_RFData,
    output logic [31:0] ME_DMData,
    output logic        ME_Stall,
    output logic        ME_BusErr,
    output logic        ME_AddrErr,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, bus_err_q, bus_err_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d, lane;
    logic        access, is_half, is_word, addr_err, start, timeout;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign access  = ME_MemRd | ME_MemWr;
    assign is_half = ME_MemOp[1:0] == 2'b01;
    assign is_word = ME_MemOp[1];
`ifdef MEM_ALIGN_CHK_EN
    assign addr_err = (is_half & ME_ALURes[0]) | (is_word & |ME_ALURes[1:0]);
    assign lane     = ME_ALURes[1:0];
`else
    assign addr_err = 1'b0;
    assign lane     = is_word ? 2'b00 : is_half ? {ME_ALURes[1], 1'b0} : ME_ALURes[1:0];
`endif
    assign start      = state_q == IDLE && access && !addr_err;
    assign ME_Stall   = start || state_q == BUSY;
    assign ME_AddrErr = state_q == IDLE && access && addr_err && !rst;
    assign ME_BusErr  = bus_err_q;
    assign ME_DMData  = data_q;
    assign dm_req     = req_q;
    assign dm_we      = we_q;
    assign dm_be      = be_q;
    assign dm_addr    = addr_q;
    assign dm_wdata   = wdata_q;
    assign timeout    = cnt_q == 8'(TIMEOUT - 1);

    // Lane and sign handling use the op/lane captured at request time, not the live inputs
    assign byte_sel = dm_rdata[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    assign load_val = op_q[1:0] == 2'b00 ? {{24{~op_q[2] & byte_sel[7]}}, byte_sel} :
                      op_q[1:0] == 2'b01 ? {{16{~op_q[2] & half_sel[15]}}, half_sel} : dm_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        op_d      = op_q;
        lane_d    = lane_q;
        bus_err_d = 1'b0;
        if (start) begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = ME_MemWr;
            be_d    = is_word ? 4'hF : is_half ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
            addr_d  = {ME_ALURes[31:2], 2'b00};
            wdata_d = is_word ? ME_RFData : is_half ? {2{ME_RFData[15:0]}} : {4{ME_RFData[7:0]}};
            op_d    = ME_MemOp;
            lane_d  = lane;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 8'd1;
            if (dm_ack || timeout) begin
                state_d   = DONE;
                req_d     = 1'b0;
                data_d    = dm_ack && !we_q ? load_val : 32'd0;
                bus_err_d = !dm_ack;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            data_q    <= 32'd0;
            op_q      <= 3'd0;
            lane_q    <= 2'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            op_q      <= op_d;
            lane_q    <= lane_d;
            bus_err_q <= bus_err_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access with a byte-level reference model.
module tb_mem_access;
    localparam int TO = 4;
    logic        clk, rst, ME_MemRd, ME_MemWr, ME_Stall, ME_BusErr, ME_AddrErr;
    logic        dm_req, dm_we, dm_ack;
    logic [2:0]  ME_MemOp;
    logic [31:0] ME_ALURes, ME_RFData, ME_DMData, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;

    typedef struct {
        logic [31:0] addr, wdata, dmdata;
        logic [3:0]  be;
        logic        we, buserr;
        int          reqs;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ME_MemRd(ME_MemRd), .ME_MemWr(ME_MemWr), .ME_MemOp(ME_MemOp),
        .ME_ALURes(ME_ALURes), .ME_RFData(ME_RFData), .ME_DMData(ME_DMData), .ME_Stall(ME_Stall),
        .ME_BusErr(ME_BusErr), .ME_AddrErr(ME_AddrErr), .dm_req(dm_req), .dm_addr(dm_addr),
        .dm_we(dm_we), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sz(input logic [2:0] op);
        return op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : 4;
    endfunction

    // Reference: access is `size` bytes at the size-aligned address, little-endian lanes
    function automatic exp_t model(input bit wr, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] rd, input int ack_at);
        exp_t e;
        longint size = sz(op), al = longint'(a) - longint'(a) % size, ln = al % 4, v;
        e.addr = 32'((al / 4) * 4);
        e.be = 4'(((64'd1 << size) - 1) << ln);
        e.we = wr;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(longint'(d) >> (8 * (i % size)));
        e.reqs = ack_at != 0 ? ack_at : TO;
        e.buserr = ack_at == 0;
        v = (longint'(rd) >> (8 * ln)) % (longint'(1) << (8 * size));
        if (!op[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
        e.dmdata = (wr || e.buserr) ? 32'd0 : 32'(v);
        return e;
    endfunction

    task automatic txn(input bit wr, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int ack_at, input bit hold);
        int busy = 0;
        @(posedge clk) #1;
        ME_MemWr  = wr;
        ME_MemRd  = wr ? 1'($urandom) : 1'b1;
        ME_MemOp  = op;
        ME_ALURes = a;
        ME_RFData = d;
`ifdef MEM_ALIGN_CHK_EN
        if (longint'(a) % sz(op) != 0) begin
            #1;
            chk("addrerr_pulse", 32'(ME_AddrErr), 32'd1);
            chk("addrerr_nostall", 32'(ME_Stall), 32'd0);
            @(posedge clk) #1;
            chk("addrerr_noreq", 32'(dm_req), 32'd0);
            {ME_MemRd, ME_MemWr} = 2'b00;
            return;
        end
`endif
        q.push_back(model(wr, op, a, d, rd, ack_at));
        forever begin
            @(posedge clk) #1;
            if (!dm_req) break;
            busy++;
            dm_ack   = busy == ack_at;
            dm_rdata = busy == ack_at ? rd : $urandom;
            if (busy > TO + 2) begin
                chk("busy_bound", 32'(busy), 32'(TO));
                break;
            end
        end
        dm_ack = 1'($urandom);
        if (hold) begin
            @(posedge clk) #1;
            chk("done_no_restart", 32'(dm_req), 32'd0);
        end
        {ME_MemRd, ME_MemWr} = 2'b00;
    endtask

    // Monitor: a falling dm_req marks the DONE cycle, where the oldest expectation is retired
    initial begin
        bit prev = 0;
        int reqs = 0, stalls = 0;
        logic [31:0] ca, cw;
        logic [3:0] cb;
        logic cwe;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0; reqs = 0; stalls = 0;
                continue;
            end
`ifndef MEM_ALIGN_CHK_EN
            chk("addrerr_off", 32'(ME_AddrErr), 32'd0);
`endif
            if (ME_Stall) stalls++;
            if (dm_req) begin
                if (!prev) {ca, cb, cwe, cw} = {dm_addr, dm_be, dm_we, dm_wdata};
                else chk("req_held", 32'({dm_addr, dm_be, dm_we, dm_wdata} != {ca, cb, cwe, cw}), 32'd0);
                chk("buserr_busy", 32'(ME_BusErr), 32'd0);
                reqs++;
            end else if (prev) begin
                if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("dm_addr", ca, e.addr);
                    chk("dm_be", 32'(cb), 32'(e.be));
                    chk("dm_we", 32'(cwe), 32'(e.we));
                    chk("dm_wdata", cw, e.wdata);
                    chk("dmdata", ME_DMData, e.dmdata);
                    chk("buserr", 32'(ME_BusErr), 32'(e.buserr));
                    chk("req_cycles", 32'(reqs), 32'(e.reqs));
                    chk("stall_cycles", 32'(stalls), 32'(e.reqs + 1));
                    chk("stall_done", 32'(ME_Stall), 32'd0);
                end
                reqs = 0; stalls = 0;
            end
            prev = dm_req;
        end
    end

    initial begin
        rst = 1; {ME_MemRd, ME_MemWr, dm_ack} = 3'b000;
        ME_MemOp = 0; ME_ALURes = 0; ME_RFData = 0; dm_rdata = 0;
        #3;
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_we_be", 32'({dm_we, dm_be}), 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_dmdata", ME_DMData, 32'd0);
        chk("rst_errs", 32'({ME_BusErr, ME_AddrErr, ME_Stall}), 32'd0);
        @(negedge clk) #1 rst = 0;
        txn(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
        txn(0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0);
        txn(0, 3'b100, 32'h103, 32'h0, 32'h80112233, 3, 1);
        txn(1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 0);
        txn(0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0, 0);
        txn(0, 3'b001, 32'h101, 32'h0, 32'hCAFEF00D, 1, 1);
        // Reset during the second BUSY cycle, then a late ack that must be ignored
        @(posedge clk) #1;
        ME_MemRd = 1; ME_MemOp = 3'b010; ME_ALURes = 32'h300;
        repeat (2) @(posedge clk) #1;
        #2 rst = 1;
        #1;
        chk("rst_mid_req", 32'(dm_req), 32'd0);
        chk("rst_mid_data", ME_DMData, 32'd0);
        ME_MemRd = 0;
        @(negedge clk) #1 rst = 0;
        dm_ack = 1; dm_rdata = $urandom;
        repeat (3) begin
            @(posedge clk) #1;
            chk("late_ack_req", 32'(dm_req), 32'd0);
            chk("late_ack_data", ME_DMData, 32'd0);
            chk("late_ack_err", 32'(ME_BusErr), 32'd0);
        end
        dm_ack = 0;
        for (int i = 0; i < 80; i++)
            txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, TO), 1'($urandom));
        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
